// File: rtl/vector_pls_bus_ctrl.sv
// rtl/vector_pls_bus_ctrl.sv - multi-beat OCP master controller for the vector PLS unit
module vector_pls_bus_ctrl #(
    parameter int BUS_ADDR_WIDTH  = 32,
    parameter int BUS_DATA_WIDTH  = 128,
    parameter int VECTOR_BEATS    = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   req_valid,
    output logic                                                   req_ready,
    input  logic                                                   req_we,
    input  logic [BUS_ADDR_WIDTH-1:0]                              req_addr,
    input  logic [BUS_DATA_WIDTH/8-1:0]                            req_byteen,
    input  logic [2:0]                                             req_cond,
    output logic [2:0]                                             MCmd,
    output logic [BUS_ADDR_WIDTH-1:0]                              MAddr,
    output logic [BUS_DATA_WIDTH/8-1:0]                            MByteEn,
    output logic                                                   MRespAccept,
    input  logic                                                   SCmdAccept,
    input  logic [1:0]                                             SResp,
    output logic                                                   capture,
    output logic                                                   stored_byteen,
    output logic [2:0]                                             cond,
    output logic [(VECTOR_BEATS > 1 ? $clog2(VECTOR_BEATS) : 1)-1:0] beat_idx,
    output logic                                                   done,
    output logic                                                   err,
    output logic                                                   busy
);
    localparam int BEW    = BUS_DATA_WIDTH / 8;
    localparam int BIW    = (VECTOR_BEATS > 1) ? $clog2(VECTOR_BEATS) : 1;
    localparam int CNT_W  = $clog2(VECTOR_BEATS + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VECTOR_BEATS - 1);
    localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WR    = 3'd1;
    localparam logic [2:0] CMD_RD    = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_we;
    logic [BUS_ADDR_WIDTH-1:0] r_addr;
    logic [BEW-1:0]        r_byteen;
    logic                  r_stored_be;
    logic [2:0]            r_cond;
    logic [CNT_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_resp_cnt;
    logic [OUT_W-1:0]      r_outstanding;
    logic                  r_err;

    logic                  w_accept_req;
    logic                  w_resp;
    logic                  w_resp_bad;
    logic                  w_present;
    logic                  w_issue;
    logic                  w_last_resp;
    logic [BUS_ADDR_WIDTH-1:0] w_offset;

    // Bus handshakes, slot availability and per-beat PLS controls
    always_comb begin
        w_accept_req = (r_state == ST_IDLE) && req_valid;
        MRespAccept  = (r_state != ST_IDLE);
        w_resp       = MRespAccept && (SResp != RESP_NULL) && (r_outstanding != '0);
        w_resp_bad   = w_resp && (SResp != RESP_DVA);
        // a response consumed this cycle frees its slot for a command in the same cycle
        w_present    = (r_state == ST_ISSUE) && ((r_outstanding < OUT_MAX) || w_resp);
        w_issue      = w_present && SCmdAccept;
        w_last_resp  = w_resp && (r_resp_cnt == LAST_BEAT);
        w_offset     = BUS_ADDR_WIDTH'(r_issued) * BUS_ADDR_WIDTH'(BEW);
        MCmd         = w_present ? (r_we ? CMD_WR : CMD_RD) : CMD_IDLE;
        MAddr        = (r_state == ST_ISSUE) ? (r_addr + w_offset) : '0;
        MByteEn      = (r_state == ST_ISSUE) ? r_byteen : '0;
        capture      = w_resp && (SResp == RESP_DVA) && !r_we;
        done         = w_last_resp;
        err          = w_last_resp && (r_err || w_resp_bad);
        busy         = (r_state != ST_IDLE);
        req_ready    = (r_state == ST_IDLE);
        beat_idx     = r_resp_cnt[BIW-1:0];
        stored_byteen = r_stored_be;
        cond         = r_cond;
    end

    // Next-state selection for the IDLE/ISSUE/DRAIN sequence
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_next_state = ST_ISSUE;
            ST_ISSUE: if (w_issue && (r_issued == LAST_BEAT)) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_last_resp) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register, request latches, beat/response/outstanding counters and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_byteen      <= '0;
            r_stored_be   <= 1'b0;
            r_cond        <= 3'd0;
            r_issued      <= '0;
            r_resp_cnt    <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept_req) begin
                r_we        <= req_we;
                r_addr      <= req_addr;
                r_byteen    <= req_byteen;
                r_stored_be <= |req_byteen;
                r_cond      <= req_cond;
                r_issued    <= '0;
                r_resp_cnt  <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_issue) r_issued <= r_issued + 1'b1;
                if (w_last_resp) begin
                    r_resp_cnt <= '0;
                    r_err      <= 1'b0;
                end else if (w_resp) begin
                    r_resp_cnt <= r_resp_cnt + 1'b1;
                    if (w_resp_bad) r_err <= 1'b1;
                end
            end
            case ({w_issue, w_resp})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end
endmodule
